// File: rtl/uart_rx.sv
// uart_rx: serial receiver, mid-bit sampling timed by a per-bit cycle counter.
// Define UART_RX_PARITY_EN for 8E1 frames with parity_err; otherwise 8N1.
module uart_rx #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_en,
  input  logic       rx_data_in,
  output logic [7:0] rx_data_out,
  output logic       start,
  output logic       busy,
  output logic       done,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;

  state_t        state;
  logic          s1;
  logic          rxs;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    sh;
  logic          tick_half;
  logic          tick_full;

`ifdef UART_RX_PARITY_EN
  logic par_bad;
  logic perr_q;
  assign parity_err = perr_q;
`else
  logic par_bad;
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  assign tick_half = (cnt == HALF_M1);
  assign tick_full = (cnt == FULL_M1);

  // Line idles high, so the synchronizer resets to 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1  <= 1'b1;
      rxs <= 1'b1;
    end else begin
      s1  <= rx_data_in;
      rxs <= s1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      sh          <= '0;
      rx_data_out <= '0;
      start       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      frame_err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad     <= 1'b0;
      perr_q      <= 1'b0;
`endif
    end else begin
      start     <= 1'b0;
      done      <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (rx_en && !rxs) begin
            cnt   <= '0;
            busy  <= 1'b1;
            state <= START;
          end
        end
        START: begin
          if (tick_half) begin
            cnt <= '0;
            if (!rxs) begin
              start <= 1'b1;
              idx   <= '0;
              state <= DATA;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (tick_full) begin
            cnt <= '0;
            sh  <= {rxs, sh[7:1]};
            idx <= idx + 1'b1;
            if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick_full) begin
            cnt     <= '0;
            par_bad <= (rxs != ^sh);
            state   <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (tick_full) begin
            cnt <= '0;
            if (!rxs) begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end else if (par_bad) begin
`ifdef UART_RX_PARITY_EN
              perr_q <= 1'b1;
`endif
              busy   <= 1'b0;
              state  <= IDLE;
            end else begin
              rx_data_out <= sh;
              done        <= 1'b1;
              busy        <= 1'b0;
              state       <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // A held-low line must return high before a new start is armed.
        BREAK: begin
          if (rxs) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
